ssd_scan_driver: RTL

- Consumes the 13-bit binary `SSD` value that the processor drives for the board's 4-digit seven-segment display.
- Converts the value to 4 BCD digits with a sequential double-dabble engine, one shift per cycle.
- Time-multiplexes the digits onto the common-anode display: active-low anodes, active-low segments.
- Sits between `processor` and the top-level board pins.

---
 rtl/ssd_scan_driver.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: binary-to-BCD conversion (sequential double dabble) and
// time-multiplexed drive of a 4-digit common-anode seven-segment display.
// Optional build macro: SSD_LEADING_ZERO_BLANK_EN (blank leading zero digits).
//
// state  | meaning
// IDLE   | wait for a new value (or first conversion after reset)
// SHIFT  | one add-3/shift iteration per cycle, 13 iterations
// COMMIT | publish scratch digits to bcd, mark display valid
module ssd_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] value,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        busy,
    output logic [15:0] bcd
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t       state, state_nxt;
    logic         load, do_shift, do_commit;
    logic [12:0]  bin_sr;
    logic [12:0]  shown;
    logic [15:0]  scratch;
    logic [15:0]  scratch_adj;
    logic [3:0]   count;
    logic         valid;
    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]   digit_idx;
    logic [3:0]   nibble;
    logic         blank;

    // Add 3 to every BCD nibble that is 5 or more before the shift
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5)
                scratch_adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state and datapath strobes
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        do_shift  = 1'b0;
        do_commit = 1'b0;
        case (state)
            IDLE: begin
                if (!valid || (value != shown)) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                do_shift = 1'b1;
                if (count == 4'd1) state_nxt = COMMIT;
            end
            COMMIT: begin
                do_commit = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Conversion datapath: capture, shift, commit
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_sr  <= '0;
            shown   <= '0;
            scratch <= '0;
            count   <= '0;
            busy    <= 1'b0;
            bcd     <= '0;
            valid   <= 1'b0;
        end else begin
            if (load) begin
                bin_sr  <= value;
                shown   <= value;
                scratch <= '0;
                count   <= 4'd13;
                busy    <= 1'b1;
            end
            if (do_shift) begin
                scratch <= {scratch_adj[14:0], bin_sr[12]};
                bin_sr  <= {bin_sr[11:0], 1'b0};
                count   <= count - 4'd1;
            end
            if (do_commit) begin
                bcd   <= scratch;
                valid <= 1'b1;
                busy  <= 1'b0;
            end
        end
    end

    // Free-running refresh timer stepping the digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    assign nibble = bcd[{digit_idx, 2'b00} +: 4];

`ifdef SSD_LEADING_ZERO_BLANK_EN
    // A digit is blank when it and every higher digit are zero; units never blank
    always_comb begin
        blank = 1'b0;
        case (digit_idx)
            2'd3: blank = (bcd[15:12] == 4'd0);
            2'd2: blank = (bcd[15:8]  == 8'd0);
            2'd1: blank = (bcd[15:4]  == 12'd0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    // Registered anode select and segment decode ({g,f,e,d,c,b,a}, active-low)
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else if (!valid) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an <= blank ? 4'b1111 : ~(4'b0001 << digit_idx);
            case (nibble)
                4'd0: seg <= 7'h40;
                4'd1: seg <= 7'h79;
                4'd2: seg <= 7'h24;
                4'd3: seg <= 7'h30;
                4'd4: seg <= 7'h19;
                4'd5: seg <= 7'h12;
                4'd6: seg <= 7'h02;
                4'd7: seg <= 7'h78;
                4'd8: seg <= 7'h00;
                4'd9: seg <= 7'h10;
                default: seg <= 7'h7F;
            endcase
        end
    end

endmodule
